// File: rtl/demux_unstriping.sv
// Receive-side 2-lane unstriping demux: alternate clk_2f words to lane 0/1.
// Optional lane-phase alignment on ALIGN_SYM when LANE_ALIGN_EN is defined.
module demux_unstriping #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
`ifdef LANE_ALIGN_EN
    ,
    parameter logic [7:0] ALIGN_SYM = 8'hBC
`endif
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] lane_0,
    output logic [WIDTH-1:0] lane_1,
    output logic             valid_0,
    output logic             valid_1,
    output logic             pair_strobe,
    output logic [CNT_W-1:0] unbal_cnt,
    output logic             aligned
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sel;
    logic             hold_v0;
    logic [WIDTH-1:0] hold_0;
    logic             unbal;

    assign unbal = hold_v0 != valid_in;

`ifdef LANE_ALIGN_EN
    logic sym;
    logic slip_pend;

    assign sym = valid_in && (data_in[7:0] == ALIGN_SYM);
`else
    assign aligned = 1'b1;
`endif

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            sel         <= 1'b0;
            hold_0      <= '0;
            hold_v0     <= 1'b0;
            lane_0      <= '0;
            lane_1      <= '0;
            valid_0     <= 1'b0;
            valid_1     <= 1'b0;
            pair_strobe <= 1'b0;
            unbal_cnt   <= '0;
`ifdef LANE_ALIGN_EN
            aligned     <= 1'b0;
            slip_pend   <= 1'b0;
`endif
        end else begin
            pair_strobe <= 1'b0;
            if (!sel) begin
                if (valid_in) hold_0 <= data_in;
                hold_v0 <= valid_in;
                sel     <= 1'b1;
`ifdef LANE_ALIGN_EN
                if (sym) aligned <= 1'b1;
`endif
            end
`ifdef LANE_ALIGN_EN
            // Symbol in odd phase: restart the pair with it as lane 0.
            else if (sym) begin
                hold_0    <= data_in;
                hold_v0   <= 1'b1;
                aligned   <= 1'b0;
                slip_pend <= 1'b1;
            end
`endif
            else begin
                lane_0      <= hold_0;
                valid_0     <= hold_v0;
                if (valid_in) lane_1 <= data_in;
                valid_1     <= valid_in;
                pair_strobe <= 1'b1;
                sel         <= 1'b0;
                if (unbal && unbal_cnt != CNT_MAX)
                    unbal_cnt <= unbal_cnt + 1'b1;
`ifdef LANE_ALIGN_EN
                if (slip_pend) aligned <= 1'b1;
                slip_pend <= 1'b0;
`endif
            end
        end
    end

endmodule
